// File: rtl/resposta_uart_tx.sv
// rtl/resposta_uart_tx.sv - sends a (command, value) response pair as two back-to-back UART frames
// Optional feature macro RESP_PARITY_EN: 8E1 frames with an even-parity bit after bit 7.
module resposta_uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dados_prontos,
  input  logic [7:0] response_command,
  input  logic [7:0] response_value,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RESP_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_next;
  logic [2:0]       bit_idx, bit_next;
  logic             byte_idx, byte_next;
  logic [7:0]       byte0, byte1;
  logic             dados_q;
  logic             tx_next, busy_next, done_next, overrun_next, latch;
  logic             trigger, bit_end;
  logic [7:0]       cur_byte;
  logic [2:0]       bit_inc;

  assign trigger  = dados_prontos & ~dados_q;
  assign bit_end  = (baud_cnt == BAUD_MAX);
  assign cur_byte = byte_idx ? byte1 : byte0;
  assign bit_inc  = bit_idx + 3'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= 1'b0;
      byte0    <= '0;
      byte1    <= '0;
      dados_q  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      byte_idx <= byte_next;
      dados_q  <= dados_prontos;
      tx       <= tx_next;
      busy     <= busy_next;
      done     <= done_next;
      overrun  <= overrun_next;
      if (latch) begin
        byte0 <= response_command;
        byte1 <= response_value;
      end
    end
  end

  always_comb begin
    state_next   = state;
    baud_next    = bit_end ? '0 : baud_cnt + CNT_W'(1);
    bit_next     = bit_idx;
    byte_next    = byte_idx;
    tx_next      = tx;
    busy_next    = busy;
    done_next    = 1'b0;
    overrun_next = 1'b0;
    latch        = 1'b0;

    // The done cycle is already IDLE, so an edge there starts a new pair instead of overrunning.
    if (trigger && state != S_IDLE) overrun_next = 1'b1;

    case (state)
      S_IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (trigger) begin
          latch      = 1'b1;
          state_next = S_START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          byte_next  = 1'b0;
          bit_next   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          bit_next   = '0;
          tx_next    = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef RESP_PARITY_EN
            state_next = S_PARITY;
            tx_next    = ^cur_byte;
`else
            state_next = S_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_next = bit_inc;
            tx_next  = cur_byte[bit_inc];
          end
        end
      end
`ifdef RESP_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (!byte_idx) begin
            state_next = S_START;
            byte_next  = 1'b1;
            tx_next    = 1'b0;
          end else begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_resposta_uart_tx.sv
// tb/tb_resposta_uart_tx.sv - scoreboard bench for resposta_uart_tx
module tb_resposta_uart_tx;

  localparam int CPB = 10;
`ifdef RESP_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CPB;
  localparam int PAIR  = 2 * FRAME;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dados_prontos = 1'b0;
  logic [7:0] response_command = 8'h00;
  logic [7:0] response_value = 8'h00;
  logic       tx, busy, done, overrun;

  resposta_uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clock(clock), .reset(reset), .dados_prontos(dados_prontos),
    .response_command(response_command), .response_value(response_value),
    .tx(tx), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [10:0] bits;
    int          start;
  } exp_frame_t;

  exp_frame_t fq[$];
  int         dq[$];
  int         oq[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic logic [10:0] frame_of(logic [7:0] b);
`ifdef RESP_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b01, b, 1'b0};
`endif
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // UART receiver: samples mid-bit and checks each completed frame against the queue.
  initial begin
    logic        rx_active;
    int          rx_cnt, rx_start, k;
    logic [10:0] rx_bits;
    exp_frame_t  e;
    rx_active = 1'b0;
    rx_cnt = 0;
    rx_start = 0;
    rx_bits = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        rx_active = 1'b0;
      end else begin
        if (!rx_active) begin
          if (tx == 1'b0) begin
            rx_active = 1'b1;
            rx_cnt = 0;
            rx_bits = '0;
            rx_start = cyc;
          end
        end else begin
          rx_cnt++;
        end
        if (rx_active && (rx_cnt % CPB) == CPB / 2) begin
          k = rx_cnt / CPB;
          rx_bits[k] = tx;
          if (k == FB - 1) begin
            rx_active = 1'b0;
            if (fq.size() == 0) begin
              check("frame_unexpected", rx_bits, 0);
            end else begin
              e = fq.pop_front();
              check("frame_bits", rx_bits, e.bits);
              check("frame_start", rx_start, e.start);
            end
          end
        end
      end
    end
  end

  // done / busy / overrun monitor
  initial begin
    int busy_run, e;
    busy_run = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busy_run = 0;
      end else begin
        if (done) begin
          check("done_busy_low", busy, 0);
          check("busy_length", busy_run, PAIR);
          busy_run = 0;
          if (dq.size() == 0) check("done_unexpected", 1, 0);
          else begin
            e = dq.pop_front();
            check("done_cycle", cyc, e);
          end
        end else if (busy) begin
          busy_run++;
        end
        if (overrun) begin
          if (oq.size() == 0) check("overrun_unexpected", 1, 0);
          else begin
            e = oq.pop_front();
            check("overrun_cycle", cyc, e);
          end
        end
      end
    end
  end

  task automatic wait_to(int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Call right after a negedge; the DUT samples the edge at the next posedge.
  task automatic send_pair(logic [7:0] cmd, logic [7:0] val, int hold, bit expect_pair, output int c);
    response_command = cmd;
    response_value = val;
    dados_prontos = 1'b1;
    c = cyc;
    if (expect_pair) begin
      fq.push_back('{frame_of(cmd), c + 1});
      fq.push_back('{frame_of(val), c + 1 + FRAME});
      dq.push_back(c + 1 + PAIR);
    end
    repeat (hold) @(negedge clock);
    dados_prontos = 1'b0;
  endtask

  task automatic drain(int limit);
    int n;
    n = 0;
    while ((fq.size() + dq.size() + oq.size()) != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", fq.size() + dq.size() + oq.size(), 0);
    repeat (30) @(negedge clock);
  endtask

  initial begin
    int c, c2;
    repeat (3) @(negedge clock);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_overrun", overrun, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("idle_tx", tx, 1);

    // single pulse, 0x09 / 0x19
    send_pair(8'h09, 8'h19, 1, 1'b1, c);
    drain(PAIR + 50);

    // level held high: one pair only
    send_pair(8'hAC, 8'h07, 500, 1'b1, c);
    drain(PAIR + 50);

    // second edge mid-pair: overrun, new inputs ignored
    send_pair(8'h5A, 8'hC3, 1, 1'b1, c);
    wait_to(c + 50);
    response_command = 8'hFF;
    response_value = 8'h00;
    dados_prontos = 1'b1;
    oq.push_back(c + 51);
    @(negedge clock);
    dados_prontos = 1'b0;
    drain(PAIR + 50);

    // edge coincident with done cycle
    send_pair(8'h0A, 8'h0A, 1, 1'b1, c);
    wait_to(c + PAIR + 1);
    check("in_done_cycle", done, 1);
    send_pair(8'h0A, 8'h0A, 1, 1'b1, c2);
    drain(2 * PAIR + 50);

    // parity-relevant pair
    send_pair(8'h07, 8'h08, 1, 1'b1, c);
    drain(PAIR + 50);

    // reset mid-frame abandons the pair
    send_pair(8'h33, 8'hCC, 1, 1'b0, c);
    wait_to(c + 35);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_busy", busy, 0);
    check("async_reset_done", done, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (300) @(negedge clock);
    check("post_reset_tx", tx, 1);
    check("post_reset_busy", busy, 0);
    check("final_queues", fq.size() + dq.size() + oq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
